// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types, select encodings and the round-robin search used by the arbiter.
package mux_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // One-hot request bit for a requester index.
  function automatic logic [3:0] idx2oh(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // First set bit of (req & ~mask) in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  // Walks from the lowest priority upward so the highest-priority hit wins.
  function automatic pick_t rr_pick(input logic [3:0] req,
                                    input logic [1:0] ptr,
                                    input logic [3:0] mask);
    logic [3:0] cand;
    logic [1:0] pos;
    pick_t      res;
    cand      = req & ~mask;
    res.found = 1'b0;
    res.idx   = 2'b00;
    for (int k = 3; k >= 0; k--) begin
      pos = ptr + 2'(k);
      if (cand[pos]) begin
        res.found = 1'b1;
        res.idx   = pos;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/selector bundle between the arbiter and its four clients.
interface mux4_rr_arbiter_if #(
  parameter int DATA_W = 1
);
  logic [3:0]        req;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] c;
  logic [DATA_W-1:0] d;
  logic [3:0]        gnt;
  logic              s1;
  logic              s0;
  logic [DATA_W-1:0] y;
  logic              valid;

  modport master (
    output req, a, b, c, d,
    input  gnt, s1, s0, y, valid
  );

  modport slave (
    input  req, a, b, c, d,
    output gnt, s1, s0, y, valid
  );
endinterface

// File: rtl/mux4_rr_arbiter_dp.sv
// Combinational 4:1 data selector steered by {s1,s0}.
module mux4_dp
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] y
);

  // Route the addressed requester's data to the output.
  always_comb begin
    y = a;
    unique case (sel)
      SEL_A:   y = a;
      SEL_B:   y = b;
      SEL_C:   y = c;
      SEL_D:   y = d;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner arbitration for a shared 4:1 selector, with a hold limit
// that forces a handover when another requester is waiting.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  mux4_rr_arbiter_if.slave bus
);

  localparam int              HOLD_W    = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [1:0]        sel_q, sel_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic              valid_q, valid_d;

  logic [DATA_W-1:0] dp_y;
  logic [3:0]        owner_oh;
  logic              others_pending;
  logic              release_now;
  logic [1:0]        next_ptr;
  pick_t             idle_pick;
  pick_t             handover_pick;

  mux4_dp #(.DATA_W(DATA_W)) u_dp (
    .sel (sel_q),
    .a   (bus.a),
    .b   (bus.b),
    .c   (bus.c),
    .d   (bus.d),
    .y   (dp_y)
  );

  // Next owner, pointer, hold count and registered data for the coming edge.
  // While BUSY, sel_q always names the owner, so it doubles as the owner index.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    y_d        = dp_y;
    valid_d    = (state_q == BUSY);

    owner_oh       = idx2oh(sel_q);
    others_pending = |(bus.req & ~owner_oh);
    release_now    = !bus.req[sel_q] ||
                     ((hold_cnt_q == HOLD_LAST) && others_pending);
    next_ptr       = sel_q + 2'd1;
    idle_pick      = rr_pick(bus.req, ptr_q, 4'b0000);
    handover_pick  = rr_pick(bus.req, next_ptr, owner_oh);

    unique case (state_q)
      IDLE: begin
        if (idle_pick.found) begin
          state_d    = BUSY;
          gnt_d      = idx2oh(idle_pick.idx);
          sel_d      = idle_pick.idx;
          hold_cnt_d = '0;
        end
      end
      BUSY: begin
        hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
        if (release_now) begin
          ptr_d = next_ptr;
          if (handover_pick.found) begin
            gnt_d      = idx2oh(handover_pick.idx);
            sel_d      = handover_pick.idx;
            hold_cnt_d = '0;
          end else begin
            state_d    = IDLE;
            gnt_d      = 4'b0000;
            hold_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // State, grant and datapath registers; reset takes effect immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 2'b00;
      hold_cnt_q <= '0;
      gnt_q      <= 4'b0000;
      sel_q      <= SEL_A;
      y_q        <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      y_q        <= y_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.s1    = sel_q[1];
  assign bus.s0    = sel_q[0];
  assign bus.y     = y_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: ownership model plus directed scenarios.
module tb_mux4_rr_arbiter;

  localparam int DW       = 4;
  localparam int MAX_HOLD = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  bit   cmp_en;

  mux4_rr_arbiter_if #(.DATA_W(DW)) bus ();

  mux4_rr_arbiter #(.DATA_W(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Owner is an integer index (-1 = nobody); held counts cycles the owner has
  // had the grant so far, capped at MAX_HOLD.
  int              m_owner;
  int              m_ptr;
  int              m_held;
  int              m_sel;
  logic [DW-1:0]   m_y;
  bit              m_valid;

  function automatic int first_in_order(input logic [3:0] r, input int p, input int excl);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (p + k) % 4;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] data_of(input int idx);
    case (idx)
      0: return bus.a;
      1: return bus.b;
      2: return bus.c;
      default: return bus.d;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner <= -1;
      m_ptr   <= 0;
      m_held  <= 0;
      m_sel   <= 0;
      m_y     <= '0;
      m_valid <= 1'b0;
    end else begin
      int  n_owner, n_ptr, n_held, n_sel, cand;
      bit  others;
      n_owner = m_owner;
      n_ptr   = m_ptr;
      n_held  = m_held;
      n_sel   = m_sel;
      if (m_owner < 0) begin
        cand = first_in_order(bus.req, m_ptr, -1);
        if (cand >= 0) begin
          n_owner = cand;
          n_sel   = cand;
          n_held  = 1;
        end
      end else begin
        others = 1'b0;
        for (int j = 0; j < 4; j++) if (j != m_owner && bus.req[j]) others = 1'b1;
        if (!bus.req[m_owner] || (m_held >= MAX_HOLD && others)) begin
          n_ptr   = (m_owner + 1) % 4;
          cand    = first_in_order(bus.req, n_ptr, m_owner);
          n_owner = cand;
          n_held  = 0;
          if (cand >= 0) begin
            n_sel  = cand;
            n_held = 1;
          end
        end else begin
          n_held = (m_held < MAX_HOLD) ? m_held + 1 : MAX_HOLD;
        end
      end
      m_y     <= data_of(m_sel);
      m_valid <= (m_owner >= 0);
      m_owner <= n_owner;
      m_ptr   <= n_ptr;
      m_held  <= n_held;
      m_sel   <= n_sel;
    end
  end

  // Every cycle: DUT outputs against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("model_gnt",   32'(bus.gnt), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      check("model_sel",   32'({bus.s1, bus.s0}), 32'(m_sel));
      check("model_y",     32'(bus.y), 32'(m_y));
      check("model_valid", 32'(bus.valid), 32'(m_valid));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    bus.req = 4'b0000;
    #2 rst = 1'b0;
  endtask

  task automatic set_data(input logic [DW-1:0] va, input logic [DW-1:0] vb,
                          input logic [DW-1:0] vc, input logic [DW-1:0] vd);
    bus.a = va;
    bus.b = vb;
    bus.c = vc;
    bus.d = vd;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    cmp_en  = 1'b0;
    rst     = 1'b1;
    bus.req = 4'b0000;
    set_data(4'h1, 4'h2, 4'h3, 4'h4);
    #12 rst = 1'b0;
    check("reset_gnt",   32'(bus.gnt), 32'h0);
    check("reset_sel",   32'({bus.s1, bus.s0}), 32'h0);
    check("reset_y",     32'(bus.y), 32'h0);
    check("reset_valid", 32'(bus.valid), 32'h0);
    cmp_en = 1'b1;

    // Reset asserted mid-BUSY clears outputs before any clock edge.
    @(negedge clk);
    bus.req = 4'b0010;
    repeat (3) @(negedge clk);
    check("busy_before_rst", 32'(bus.gnt), 32'h2);
    #2 rst = 1'b1;
    #1;
    check("midrst_gnt",   32'(bus.gnt), 32'h0);
    check("midrst_sel",   32'({bus.s1, bus.s0}), 32'h0);
    check("midrst_y",     32'(bus.y), 32'h0);
    check("midrst_valid", 32'(bus.valid), 32'h0);
    #1 rst = 1'b0;

    // Single requester c.
    do_reset();
    set_data(4'h0, 4'h0, 4'h1, 4'h0);
    @(negedge clk);
    bus.req = 4'b0100;
    @(negedge clk);
    check("single_gnt", 32'(bus.gnt), 32'h4);
    check("single_sel", 32'({bus.s1, bus.s0}), 32'h2);
    @(negedge clk);
    check("single_valid", 32'(bus.valid), 32'h1);
    check("single_y",     32'(bus.y), 32'h1);

    // Full contention with hold limit 4.
    do_reset();
    set_data(4'h1, 4'h2, 4'h3, 4'h4);
    @(negedge clk);
    bus.req = 4'b1111;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      check("contend_gnt", 32'(bus.gnt), 32'd1 << ((i / 4) % 4));
      if (i >= 1) check("contend_valid", 32'(bus.valid), 32'h1);
    end

    // Voluntary release moves the pointer past the owner.
    do_reset();
    set_data(4'h5, 4'h6, 4'h7, 4'h8);
    @(negedge clk);
    bus.req = 4'b0001;
    @(negedge clk);
    check("vol_gnt_a", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0110;
    @(negedge clk);
    check("vol_gnt_b", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0100;
    @(negedge clk);
    check("vol_gnt_c", 32'(bus.gnt), 32'h4);
    check("vol_ptr",   32'(dut.ptr_q), 32'h2);

    // Lone requester keeps the grant; hold count saturates.
    do_reset();
    @(negedge clk);
    bus.req = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("lone_gnt", 32'(bus.gnt), 32'h1);
      if (i >= 1) check("lone_valid", 32'(bus.valid), 32'h1);
    end
    check("lone_hold_sat", 32'(dut.hold_cnt_q), 32'(MAX_HOLD - 1));

    // Owner d drops with nobody else waiting.
    do_reset();
    @(negedge clk);
    bus.req = 4'b1000;
    repeat (2) @(negedge clk);
    check("drop_gnt_d", 32'(bus.gnt), 32'h8);
    bus.req = 4'b0000;
    @(negedge clk);
    check("drop_gnt_idle",   32'(bus.gnt), 32'h0);
    check("drop_valid_hold", 32'(bus.valid), 32'h1);
    @(negedge clk);
    check("drop_valid_low", 32'(bus.valid), 32'h0);

    // Owner d drops while b rises on the same edge.
    bus.req = 4'b1000;
    repeat (2) @(negedge clk);
    check("swap_gnt_d", 32'(bus.gnt), 32'h8);
    bus.req = 4'b0010;
    @(negedge clk);
    check("swap_gnt_b",   32'(bus.gnt), 32'h2);
    check("swap_valid",   32'(bus.valid), 32'h1);
    @(negedge clk);
    check("swap_y_b",     32'(bus.y), 32'h6);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one 4:1 selector between four requesters (a, b, c, d). It grants one owner at a time and drives the select lines s1/s0. It registers the selected data onto y with a valid flag. A hold limit stops one requester from starving the others.

## Interface
- DATA_W, 1, width of each data input and of y
- MAX_HOLD, 8, max consecutive grant cycles while another request is pending (≥2)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  4  request vector, bit0=a, bit1=b, bit2=c, bit3=d
- a, b, c, d  in  DATA_W  requester data
- gnt  out  4  one-hot grant, registered
- s1, s0  out  1  select, {s1,s0}: 00=a, 01=b, 10=c, 11=d
- y  out  DATA_W  registered selected data
- valid  out  1  y carries owner data

## Operation
- States: IDLE (no owner, gnt=0), BUSY (one owner, gnt one-hot).
- Pointer ptr (2 b) holds the highest-priority index. Search order is ptr, ptr+1, ptr+2, ptr+3, mod 4.
- IDLE, any req:
  - grant the first requester in search order;
  - set {s1,s0} to that index;
  - hold_cnt=0;
  - go to BUSY.
- IDLE, no req: stay in IDLE. s1/s0 hold their last value.
- BUSY, each edge: hold_cnt increments and saturates at MAX_HOLD-1.
- Release when either:
  - R1: req[owner]=0, or
  - R2: hold_cnt==MAX_HOLD-1 and any other req bit is set.
- On release:
  - ptr ← owner+1 mod 4;
  - arbitrate among req with the owner bit masked;
  - if a candidate exists, grant it in the same edge: stay BUSY, hold_cnt=0, no idle gap;
  - otherwise go to IDLE and gnt=0.
- No other requester pending: the owner keeps the grant indefinitely and R2 never fires.
- Datapath, every edge:
  - y ← input selected by the current {s1,s0};
  - valid ← (state==BUSY).
- hold_cnt width is $clog2(MAX_HOLD).

## Timing
- Reset, asynchronous and immediate, including mid-BUSY:
  - state=IDLE, gnt=0000, s1=s0=0;
  - y=0, valid=0, ptr=0, hold_cnt=0.
- Request to grant:
  - req sampled at edge k; gnt and s1/s0 update after edge k.
  - y and valid for that owner appear after edge k+1, so one-cycle select-to-data latency.
  - Total latency is 2 edges.
- Grant handover:
  - gnt switches owner on a single edge;
  - y shows the old owner's data for one more cycle, then the new owner's;
  - valid stays 1 throughout.
- Owner drop with no other requester: gnt=0 after the drop edge, valid=0 one edge later.
- Owner drops and another bit rises on the same edge: the new bit is eligible in that arbitration.
- Owner bit re-rising on the release edge is masked for that edge only.

## Structure
- Package mux_arb_pkg:
  - state enum {IDLE, BUSY};
  - select constants SEL_A=2'b00 … SEL_D=2'b11;
  - pure function rr_pick(req, ptr, mask), returning found flag and index.
- Sub-module mux4_dp: combinational 4:1 DATA_W selector on {s1,s0}. The arbiter registers its output into y.
- Top module holds the FSM, ptr, hold_cnt and the y/valid registers.

## Test plan
- Reset mid-BUSY:
  - stimulus: req=0010, wait 3 cycles, pulse rst between edges;
  - required: gnt=0000, s1s0=00, y=0, valid=0 immediately, before the next edge.
- Single requester:
  - stimulus: after reset, req=0100, c=1, others 0;
  - required: edge1 gnt=0100, s1s0=10; edge2 valid=1, y=1.
- Full contention, MAX_HOLD=4:
  - stimulus: req=1111 held;
  - required: gnt sequence 0001×4, 0010×4, 0100×4, 1000×4, then 0001; valid stays 1 with no gap.
- Voluntary release with pointer:
  - stimulus: owner a (gnt=0001), req drops to 0110 on one edge;
  - required: next gnt=0010 (b), ptr=2; when b drops with req=0100, gnt=0100.
- No competition:
  - stimulus: req=0001 held 20 cycles, MAX_HOLD=4;
  - required: gnt stays 0001 throughout, hold_cnt saturates at 3, valid continuous.
- Drop to idle and same-edge rise:
  - stimulus: owner d drops while req=0000;
  - required: gnt=0000 next edge, valid=0 one edge later.
  - stimulus: owner d drops while b rises on the same edge;
  - required: gnt=0010 on that edge.
